// File: rtl/nn_pkg.sv
// Shared types and constants for the two-layer neural network sequencer:
// FSM states, weight-memory map bases, accumulator width and saturation.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HID,
        OUT,
        DONE
    } state_t;

    localparam logic [6:0] HID_BIAS_BASE = 7'd64;
    localparam logic [6:0] OUT_W_BASE    = 7'd72;
    localparam logic [6:0] OUT_BIAS_BASE = 7'd104;

    localparam int ACC_W = 20;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd128;

    function automatic logic signed [7:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return 8'h7F;
        if (v < SAT_MIN) return 8'h80;
        return v[7:0];
    endfunction

endpackage

// File: rtl/nn_mac.sv
// Shared multiply/accumulate datapath: taps accumulate signed products,
// finalize adds the bias, shifts, saturates, optionally applies ReLU.
module nn_mac
    import nn_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tap_en,
    input  logic              clear,
    input  logic              fin_en,
    input  logic              relu_en,
    input  logic signed [7:0] act,
    input  logic signed [7:0] wt,
    output logic signed [7:0] result,
    output logic              result_valid
);

    logic signed [15:0]      product;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    logic signed [7:0]       clipped;

    // During a finalize cycle the weight bus carries the neuron's bias.
    always_comb begin
        product  = $signed({{8{act[7]}}, act}) * $signed({{8{wt[7]}}, wt});
        prod_ext = {{(ACC_W-16){product[15]}}, product};
        bias_ext = {{(ACC_W-8){wt[7]}}, wt};
        acc_base = clear ? '0 : acc;
        biased   = acc + bias_ext;
        shifted  = biased >>> SHIFT;
        clipped  = saturate(shifted);
        if (relu_en && clipped[7]) begin
            clipped = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= fin_en;
            if (tap_en) begin
                acc <= acc_base + prod_ext;
            end
            if (fin_en) begin
                result <= clipped;
            end
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexes one MAC across a hidden and an output layer fed from an
// external weight memory. Optional argmax output: define NN_ARGMAX_EN.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NIN   = 8,
    parameter int NH    = 8,
    parameter int NO    = 4,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*NIN-1:0] in_data,
    output logic [6:0]       wt_addr,
    input  logic [7:0]       wt_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef NN_ARGMAX_EN
    output logic [8*NO-1:0]  out_data,
    output logic [1:0]       out_class
`else
    output logic [8*NO-1:0]  out_data
`endif
);

    localparam logic [7:0] HID_TAPS = 8'(NIN);
    localparam logic [7:0] OUT_TAPS = 8'(NH);
    localparam logic [7:0] LAST_HID = 8'(NH - 1);
    localparam logic [7:0] LAST_OUT = 8'(NO - 1);
    localparam int XIW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int HIW = (NH > 1) ? $clog2(NH) : 1;
    localparam int OIW = (NO > 1) ? $clog2(NO) : 1;

    state_t            state;
    logic [7:0]        tap_cnt;
    logic [7:0]        neuron;
    logic [7:0]        wr_idx;
    logic              wr_out;
    logic              pre_out;
    logic [7:0]        pre_tap;
    logic [7:0]        pre_neuron;
    logic              base_out;
    logic [7:0]        base_tap;
    logic [7:0]        base_neuron;
    logic              nxt_out;
    logic [7:0]        nxt_tap;
    logic [7:0]        nxt_neuron;
    logic [6:0]        nxt_addr;
    logic [7:0]        cur_taps;
    logic              busy;
    logic signed [7:0] x_q   [NIN];
    logic signed [7:0] hbuf  [NH];
    logic signed [7:0] out_q [NO];
    logic              mac_tap;
    logic              mac_fin;
    logic              mac_clear;
    logic              mac_relu;
    logic              mac_valid;
    logic signed [7:0] mac_act;
    logic signed [7:0] mac_result;

    // The pre_* pointer names the item whose address sits on wt_addr; it runs
    // one item ahead of the tap being consumed, matching the memory latency.
    always_comb begin
        base_out    = (state == IDLE) ? 1'b0 : pre_out;
        base_tap    = (state == IDLE) ? '0   : pre_tap;
        base_neuron = (state == IDLE) ? '0   : pre_neuron;
        nxt_out     = base_out;
        nxt_tap     = base_tap;
        nxt_neuron  = base_neuron;
        if (base_tap < (base_out ? OUT_TAPS : HID_TAPS)) begin
            nxt_tap = base_tap + 8'd1;
        end else begin
            nxt_tap = '0;
            if (base_neuron < (base_out ? LAST_OUT : LAST_HID)) begin
                nxt_neuron = base_neuron + 8'd1;
            end else begin
                nxt_neuron = '0;
                nxt_out    = 1'b1;
            end
        end
        if (nxt_out) begin
            nxt_addr = (nxt_tap == OUT_TAPS)
                     ? 7'(int'(OUT_BIAS_BASE) + int'(nxt_neuron))
                     : 7'(int'(OUT_W_BASE) + int'(nxt_neuron) * NH + int'(nxt_tap));
        end else begin
            nxt_addr = (nxt_tap == HID_TAPS)
                     ? 7'(int'(HID_BIAS_BASE) + int'(nxt_neuron))
                     : 7'(int'(nxt_neuron) * NIN + int'(nxt_tap));
        end
    end

    always_comb begin
        busy      = (state == HID) || (state == OUT);
        cur_taps  = (state == OUT) ? OUT_TAPS : HID_TAPS;
        mac_tap   = busy && (tap_cnt < cur_taps);
        mac_fin   = busy && (tap_cnt == cur_taps);
        mac_clear = (tap_cnt == '0);
        mac_relu  = (state == HID);
        mac_act   = (state == OUT) ? hbuf[tap_cnt[HIW-1:0]] : x_q[tap_cnt[XIW-1:0]];
    end

    nn_mac #(
        .SHIFT(SHIFT)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .tap_en      (mac_tap),
        .clear       (mac_clear),
        .fin_en      (mac_fin),
        .relu_en     (mac_relu),
        .act         (mac_act),
        .wt          ($signed(wt_data)),
        .result      (mac_result),
        .result_valid(mac_valid)
    );

    // A finalized result lands one cycle after its finalize edge, so the last
    // output lane and out_valid appear together on the first DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            wt_addr    <= '0;
            tap_cnt    <= '0;
            neuron     <= '0;
            wr_idx     <= '0;
            wr_out     <= 1'b0;
            pre_out    <= 1'b0;
            pre_tap    <= '0;
            pre_neuron <= '0;
            for (int i = 0; i < NIN; i++) x_q[i]   <= '0;
            for (int i = 0; i < NH; i++)  hbuf[i]  <= '0;
            for (int i = 0; i < NO; i++)  out_q[i] <= '0;
        end else begin
            if (mac_valid) begin
                if (wr_out) begin
                    out_q[wr_idx[OIW-1:0]] <= mac_result;
                end else begin
                    hbuf[wr_idx[HIW-1:0]] <= mac_result;
                end
            end
            case (state)
                IDLE: begin
                    wt_addr <= '0;
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < NIN; i++) x_q[i] <= in_data[8*i +: 8];
                        state      <= HID;
                        in_ready   <= 1'b0;
                        tap_cnt    <= '0;
                        neuron     <= '0;
                        pre_out    <= nxt_out;
                        pre_tap    <= nxt_tap;
                        pre_neuron <= nxt_neuron;
                        wt_addr    <= nxt_addr;
                    end
                end
                HID, OUT: begin
                    pre_out    <= nxt_out;
                    pre_tap    <= nxt_tap;
                    pre_neuron <= nxt_neuron;
                    wt_addr    <= nxt_addr;
                    if (mac_fin) begin
                        wr_idx  <= neuron;
                        wr_out  <= (state == OUT);
                        tap_cnt <= '0;
                        if (state == HID && neuron == LAST_HID) begin
                            state  <= OUT;
                            neuron <= '0;
                        end else if (state == OUT && neuron == LAST_OUT) begin
                            state  <= DONE;
                            neuron <= '0;
                        end else begin
                            neuron <= neuron + 8'd1;
                        end
                    end else begin
                        tap_cnt <= tap_cnt + 8'd1;
                    end
                end
                DONE: begin
                    wt_addr <= '0;
                    if (mac_valid && wr_out && wr_idx == LAST_OUT) begin
                        out_valid <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NO; g++) begin : g_out
        assign out_data[8*g +: 8] = out_q[g];
    end

`ifdef NN_ARGMAX_EN
    logic signed [7:0] lane_next [NO];
    logic [1:0]        class_next;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        for (int i = 0; i < NO; i++) begin
            lane_next[i] = (mac_valid && wr_out && wr_idx == 8'(i)) ? mac_result : out_q[i];
        end
        class_next = 2'd0;
        for (int i = 1; i < NO; i++) begin
            if (lane_next[i] > lane_next[class_next]) class_next = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_class <= '0;
        end else if (mac_valid && wr_out) begin
            out_class <= class_next;
        end
    end
`endif

endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameter NIN, default 8, meaning inputs per hidden neuron.
REQ-002 SHALL have parameter NH, default 8, meaning hidden neurons.
REQ-003 SHALL have parameter NO, default 4, meaning output neurons.
REQ-004 SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied before saturation.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid  input  1  input vector valid.
REQ-008 SHALL have port in_ready  output  1  block idle and able to accept a vector.
REQ-009 SHALL have port in_data  input  8*NIN  signed inputs x1..x8, x1 in the LSBs.
REQ-010 SHALL have port wt_addr  output  7  weight/bias memory read address.
REQ-011 SHALL have port wt_data  input  8  signed read data, valid one cycle after wt_addr.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_data  output  8*NO  signed outputs o1..o4, o1 in the LSBs.

Function
REQ-015 SHALL time-multiplex one MAC across all NH hidden neurons, then all NO output neurons.
REQ-016 SHALL map memory as follows: hidden weight n,k at n*NIN+k (0..63), hidden bias n at 64+n, output weight j,n at 72+j*NH+n, output bias j at 104+j.
REQ-017 SHALL use states IDLE, HID, OUT and DONE.
REQ-018 SHALL go IDLE->HID on in_valid&&in_ready, latching in_data and issuing address 0 in that cycle.
REQ-019 SHALL, in HID, spend 8 tap cycles plus 1 finalize cycle on each neuron (9 cycles), with the next address always issued one cycle ahead.
REQ-020 SHALL go HID->OUT after hidden neuron NH-1 finalizes, and OUT->DONE after output neuron NO-1 finalizes.
REQ-021 SHALL, in DONE, hold out_valid=1 and out_data stable until out_ready, then go to IDLE.
REQ-022 SHALL assert out_valid exactly 1+9*(NH+NO) cycles after the accept edge (109 at defaults).
REQ-023 SHALL assert in_ready only in IDLE, so a new accept never overlaps a pending result.
REQ-024 SHALL form products as 16-bit signed and accumulate in a 20-bit signed accumulator cleared at the first tap.
REQ-025 SHALL, at finalize, add the sign-extended bias, arithmetic-shift right by SHIFT, then saturate to [-128,127].
REQ-026 SHALL apply ReLU (negative values become 0) to hidden results only; output results are not clamped below.
REQ-027 SHALL store hidden results in an 8-entry internal buffer that feeds the output-layer taps.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, in_ready=1 (visible once rst_n=1), out_valid=0, out_data=0, wt_addr=0, accumulator=0 and hidden buffer=0.
REQ-029 SHALL abandon any computation in progress on reset, with no partial result emitted afterwards.

Configuration
REQ-030 SHALL compile in, when NN_ARGMAX_EN is defined, an extra output out_class [1:0] giving the index of the largest out_data lane, with ties resolved to the lowest index, registered with out_data.
REQ-031 SHALL, when NN_ARGMAX_EN is undefined, have neither the out_class port nor its logic, and all other behaviour is unchanged.

Structure
REQ-032 SHALL take the state enum, the address-map base constants (64, 72, 104), the accumulator width (20) and the saturation bounds from shared package nn_pkg.
REQ-033 SHALL instantiate the multiply/accumulate/bias/shift/saturate datapath as sub-module nn_mac; sequencing stays in nn_layer_sequencer.

Verification
REQ-034 SHALL pass this case: all weights=1, biases=0, SHIFT=0, inputs all 1 -> every hidden value 8, out_data lanes all 64, out_valid at cycle 109.
REQ-035 SHALL pass this case: all weights=127, inputs all 127 -> hidden values saturate to 127; output lanes saturate to 127.
REQ-036 SHALL pass this case: hidden weights=-1 (0xFF), inputs all 1, output biases 3,-8,14,5 -> hidden values all 0 (ReLU); out_data = 3,-8,14,5.
REQ-037 SHALL pass this case: out_ready held 0 for 20 cycles after out_valid -> out_data unchanged, in_ready=0 throughout, and IDLE is entered the cycle after out_ready=1.
REQ-038 SHALL pass this case: rst_n pulsed low at cycle 50 of a computation -> out_valid stays 0, in_ready=1 after release, and the next vector produces a correct result at +109.
REQ-039 SHALL pass this case, with NN_ARGMAX_EN defined: out_data lanes 10,40,40,-3 -> out_class=1.
